// File: rtl/tpu_pkg.sv
// Shared constants for the systolic GEMM engine: FSM encoding, default geometry and drain length.
// The tile helper turns element counts into tile counts.
package tpu_pkg;

  localparam int unsigned TPU_ARRAY_DIM = 4;
  localparam int unsigned TPU_DATA_W    = 8;
  localparam int unsigned TPU_ACC_W     = 32;
  localparam int unsigned TPU_ADDR_W    = 16;

  // Cycles for the last operand to ripple from PE(0,0) to PE(N-1,N-1).
  localparam int unsigned DRAIN_CYCLES  = 2 * TPU_ARRAY_DIM - 1;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StFeed  = 3'd1;
  localparam state_t StDrain = 3'd2;
  localparam state_t StWrite = 3'd3;
  localparam state_t StDone  = 3'd4;

  function automatic logic [7:0] tile_count(input logic [7:0] dim, input int unsigned tile_edge);
    int unsigned t;
    t = (32'(dim) + tile_edge - 1) / tile_edge;
    return 8'(t);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary processing element: signed MAC into a local accumulator,
// with registered pass-through of the A operand rightwards and B operand downwards.
module systolic_pe
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = TPU_DATA_W,
  parameter int unsigned ACC_W  = TPU_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic        [ACC_W-1:0]    prod_ext;

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o   <= '0;
      b_o   <= '0;
      acc_o <= '0;
    end else begin
      a_o <= a_i;
      b_o <= b_i;
      // Clear wins over MAC so a new tile starts from zero regardless of pipeline contents.
      if (clear_i) begin
        acc_o <= '0;
      end else begin
        acc_o <= acc_o + prod_ext;
      end
    end
  end

endmodule

// File: rtl/tpu_systolic_core.sv
// Output-stationary systolic GEMM engine: C = A * B with int8 operands and 32-bit accumulation.
// Walks output tiles mt-major, streams K operand words per tile, drains, then writes the tile rows.
module tpu_systolic_core
  import tpu_pkg::*;
#(
  parameter int unsigned ARRAY_DIM = TPU_ARRAY_DIM,
  parameter int unsigned DATA_W    = TPU_DATA_W,
  parameter int unsigned ACC_W     = TPU_ACC_W,
  parameter int unsigned ADDR_W    = TPU_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [7:0]                  M,
  input  logic [7:0]                  K,
  input  logic [7:0]                  N,
  output logic                        busy,
  output logic [ADDR_W-1:0]           A_index,
  input  logic [ARRAY_DIM*DATA_W-1:0] A_data_out,
  output logic [ADDR_W-1:0]           B_index,
  input  logic [ARRAY_DIM*DATA_W-1:0] B_data_out,
  output logic                        C_wr_en,
  output logic [ADDR_W-1:0]           C_index,
  output logic [ARRAY_DIM*ACC_W-1:0]  C_data_in
);

  localparam int unsigned RowW      = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam logic [7:0]  DrainLast = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0]  WriteLast = 8'(ARRAY_DIM - 1);

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [7:0]                k_q, k_d;
  logic [7:0]                mt_q, mt_d, nt_q, nt_d;
  logic [7:0]                mt_tot_q, mt_tot_d, nt_tot_q, nt_tot_d;
  logic [ADDR_W-1:0]         a_base_q, a_base_d, b_base_q, b_base_d;
  logic [ADDR_W-1:0]         a_idx_q, a_idx_d, b_idx_q, b_idx_d;
  logic [ADDR_W-1:0]         c_next_q, c_next_d, c_idx_q, c_idx_d;
  logic                      c_wr_q, c_wr_d;
  logic [ARRAY_DIM*ACC_W-1:0] c_data_q, c_data_d;
  logic                      feed_v_q;

  logic                      acc_clear;
  logic                      wr_load;
  logic [RowW-1:0]           row_sel;
  logic [ARRAY_DIM*ACC_W-1:0] c_row;
  logic [ADDR_W-1:0]         k_ext;

  assign k_ext     = ADDR_W'(k_q);
  assign acc_clear = (state_q == StFeed) && (cnt_q == 8'd0);

  // Row r is captured one cycle before it is written; by then its last MAC has landed.
  assign wr_load = ((state_q == StDrain) && (cnt_q == DrainLast)) ||
                   ((state_q == StWrite) && (cnt_q != WriteLast));
  assign row_sel = (state_q == StWrite) ? RowW'(cnt_q) + RowW'(1) : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    mt_d     = mt_q;
    nt_d     = nt_q;
    mt_tot_d = mt_tot_q;
    nt_tot_d = nt_tot_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    a_idx_d  = a_idx_q;
    b_idx_d  = b_idx_q;
    c_next_d = c_next_q;
    c_idx_d  = c_idx_q;
    c_data_d = c_data_q;
    c_wr_d   = wr_load;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          k_d      = K;
          mt_tot_d = tile_count(M, ARRAY_DIM);
          nt_tot_d = tile_count(N, ARRAY_DIM);
          mt_d     = '0;
          nt_d     = '0;
          cnt_d    = '0;
          a_base_d = '0;
          b_base_d = '0;
          a_idx_d  = '0;
          b_idx_d  = '0;
          c_next_d = '0;
          state_d  = ((M == 8'd0) || (K == 8'd0) || (N == 8'd0)) ? StDone : StFeed;
        end
      end
      StFeed: begin
        if (cnt_q == k_q - 8'd1) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          a_idx_d = a_idx_q + ADDR_W'(1);
          b_idx_d = b_idx_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrite: begin
        if (cnt_q == WriteLast) begin
          cnt_d = '0;
          if (nt_q + 8'd1 < nt_tot_q) begin
            nt_d     = nt_q + 8'd1;
            b_base_d = b_base_q + k_ext;
            a_idx_d  = a_base_q;
            b_idx_d  = b_base_q + k_ext;
            state_d  = StFeed;
          end else if (mt_q + 8'd1 < mt_tot_q) begin
            mt_d     = mt_q + 8'd1;
            nt_d     = '0;
            a_base_d = a_base_q + k_ext;
            b_base_d = '0;
            a_idx_d  = a_base_q + k_ext;
            b_idx_d  = '0;
            state_d  = StFeed;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (wr_load) begin
      c_idx_d  = c_next_q;
      c_next_d = c_next_q + ADDR_W'(1);
      c_data_d = c_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      k_q      <= '0;
      mt_q     <= '0;
      nt_q     <= '0;
      mt_tot_q <= '0;
      nt_tot_q <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      a_idx_q  <= '0;
      b_idx_q  <= '0;
      c_next_q <= '0;
      c_idx_q  <= '0;
      c_wr_q   <= 1'b0;
      c_data_q <= '0;
      feed_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      mt_q     <= mt_d;
      nt_q     <= nt_d;
      mt_tot_q <= mt_tot_d;
      nt_tot_q <= nt_tot_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      a_idx_q  <= a_idx_d;
      b_idx_q  <= b_idx_d;
      c_next_q <= c_next_d;
      c_idx_q  <= c_idx_d;
      c_wr_q   <= c_wr_d;
      c_data_q <= c_data_d;
      feed_v_q <= (state_q == StFeed);
    end
  end

  // Buffer words are valid the cycle after a FEED index; outside that window inject zeros.
  logic [DATA_W-1:0] a_edge [ARRAY_DIM];
  logic [DATA_W-1:0] b_edge [ARRAY_DIM];

  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_skew
    logic [DATA_W-1:0] a_lane, b_lane;
    assign a_lane = feed_v_q ? A_data_out[i*DATA_W +: DATA_W] : '0;
    assign b_lane = feed_v_q ? B_data_out[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_lane;
      assign b_edge[i] = b_lane;
    end else begin : g_delay
      logic [DATA_W-1:0] a_sr_q [i];
      logic [DATA_W-1:0] b_sr_q [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else begin
          a_sr_q[0] <= a_lane;
          b_sr_q[0] <= b_lane;
          for (int s = 1; s < i; s++) begin
            a_sr_q[s] <= a_sr_q[s-1];
            b_sr_q[s] <= b_sr_q[s-1];
          end
        end
      end
      assign a_edge[i] = a_sr_q[i-1];
      assign b_edge[i] = b_sr_q[i-1];
    end
  end

  logic [DATA_W-1:0] a_pass [ARRAY_DIM][ARRAY_DIM];
  logic [DATA_W-1:0] b_pass [ARRAY_DIM][ARRAY_DIM];
  logic [ACC_W-1:0]  acc    [ARRAY_DIM][ARRAY_DIM];

  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_row
    for (genvar j = 0; j < ARRAY_DIM; j++) begin : g_col
      logic [DATA_W-1:0] a_in, b_in;
      if (j == 0) begin : g_a_edge
        assign a_in = a_edge[i];
      end else begin : g_a_pass
        assign a_in = a_pass[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_edge[j];
      end else begin : g_b_pass
        assign b_in = b_pass[i-1][j];
      end
      systolic_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(acc_clear),
        .a_i    (a_in),
        .b_i    (b_in),
        .a_o    (a_pass[i][j]),
        .b_o    (b_pass[i][j]),
        .acc_o  (acc[i][j])
      );
    end
  end

  // Operands leaving the right and bottom edges are dropped.
  logic unused_pass;
  always_comb begin
    unused_pass = 1'b0;
    for (int e = 0; e < ARRAY_DIM; e++) begin
      unused_pass = unused_pass ^ (^a_pass[e][ARRAY_DIM-1]) ^ (^b_pass[ARRAY_DIM-1][e]);
    end
  end

  always_comb begin
    c_row = '0;
    for (int j = 0; j < ARRAY_DIM; j++) begin
      c_row[j*ACC_W +: ACC_W] = acc[row_sel][j];
    end
  end

  assign busy      = (state_q != StIdle);
  assign A_index   = a_idx_q;
  assign B_index   = b_idx_q;
  assign C_wr_en   = c_wr_q;
  assign C_index   = c_idx_q;
  assign C_data_in = c_data_q;

endmodule

// File: tb/tb_tpu_systolic_core.sv
// Scoreboard bench for tpu_systolic_core: a matrix-level reference model predicts every C row
// write; a monitor pops and compares on each C_wr_en.
module tb_tpu_systolic_core;

  typedef struct packed {
    logic [15:0]  idx;
    logic [127:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   M = '0, K = '0, N = '0;
  logic         busy;
  logic [15:0]  A_index, B_index, C_index;
  logic [31:0]  A_data_out, B_data_out;
  logic         C_wr_en;
  logic [127:0] C_data_in;

  logic [31:0]  a_mem [0:1023];
  logic [31:0]  b_mem [0:1023];
  int           a_mat [0:15][0:15];
  int           b_mat [0:15][0:15];
  wr_t          sb [$];
  int           total = 0;
  int           bad = 0;
  int           busy_cycles = 0;

  tpu_systolic_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .M         (M),
    .K         (K),
    .N         (N),
    .busy      (busy),
    .A_index   (A_index),
    .A_data_out(A_data_out),
    .B_index   (B_index),
    .B_data_out(B_data_out),
    .C_wr_en   (C_wr_en),
    .C_index   (C_index),
    .C_data_in (C_data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    A_data_out <= a_mem[A_index[9:0]];
    B_data_out <= b_mem[B_index[9:0]];
  end

  always @(negedge clk) if (busy) busy_cycles++;

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && C_wr_en) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_c_write got idx=%0d data=%h want no write", C_index, C_data_in);
      end else begin
        e = sb.pop_front();
        if (C_index !== e.idx || C_data_in !== e.data) begin
          bad++;
          $display("FAIL c_write got idx=%0d data=%h want idx=%0d data=%h",
                   C_index, C_data_in, e.idx, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  function automatic int ceil4(input int d);
    return (d + 3) / 4;
  endfunction

  function automatic int exp_busy(input int m, input int k, input int n);
    if (m == 0 || k == 0 || n == 0) return 1;
    return ceil4(m) * ceil4(n) * (k + 11) + 1;
  endfunction

  // mode 0: random int8, 1: A identity / B = 1..16 row-major, 2: all -128
  task automatic prep(input int m, input int k, input int n, input int mode);
    wr_t         e;
    logic [31:0] w;
    int          acc, row, col;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        case (mode)
          1: begin a_mat[i][j] = (i == j) ? 1 : 0; b_mat[i][j] = i * 4 + j + 1; end
          2: begin a_mat[i][j] = -128; b_mat[i][j] = -128; end
          default: begin
            a_mat[i][j] = int'($urandom_range(0, 255)) - 128;
            b_mat[i][j] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    end
    for (int mt = 0; mt < ceil4(m); mt++) begin
      for (int kk = 0; kk < k; kk++) begin
        w = '0;
        for (int i = 0; i < 4; i++) if (4 * mt + i < m) w[i*8 +: 8] = 8'(a_mat[4*mt+i][kk]);
        a_mem[mt*k+kk] = w;
      end
    end
    for (int nt = 0; nt < ceil4(n); nt++) begin
      for (int kk = 0; kk < k; kk++) begin
        w = '0;
        for (int j = 0; j < 4; j++) if (4 * nt + j < n) w[j*8 +: 8] = 8'(b_mat[kk][4*nt+j]);
        b_mem[nt*k+kk] = w;
      end
    end
    if (m != 0 && k != 0 && n != 0) begin
      for (int mt = 0; mt < ceil4(m); mt++) begin
        for (int nt = 0; nt < ceil4(n); nt++) begin
          for (int r = 0; r < 4; r++) begin
            e.idx  = 16'((mt * ceil4(n) + nt) * 4 + r);
            e.data = '0;
            for (int j = 0; j < 4; j++) begin
              acc = 0;
              row = 4 * mt + r;
              col = 4 * nt + j;
              if (row < m && col < n) for (int kk = 0; kk < k; kk++) acc += a_mat[row][kk] * b_mat[kk][col];
              e.data[j*32 +: 32] = 32'(acc);
            end
            sb.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic start_run(input int m, input int k, input int n);
    @(negedge clk);
    M = 8'(m);
    K = 8'(k);
    N = 8'(n);
    in_valid = 1'b1;
    busy_cycles = 0;
    @(negedge clk);
    in_valid = 1'b0;
    M = 8'($urandom);
    K = 8'($urandom);
    N = 8'($urandom);
  endtask

  task automatic wait_done(input int exp_b, input string name);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got busy stuck high want busy low", name);
    end else begin
      check({name, "_busy_cycles"}, 128'(busy_cycles), 128'(exp_b));
    end
    check({name, "_writes_pending"}, 128'(sb.size()), 128'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int m, input int k, input int n, input int mode, input string name);
    prep(m, k, n, mode);
    start_run(m, k, n);
    wait_done(exp_busy(m, k, n), name);
  endtask

  initial begin
    int guard;
    int rm, rk, rn;
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_c_wr_en", 128'(C_wr_en), 128'd0);
    check("rst_a_index", 128'(A_index), 128'd0);
    check("rst_b_index", 128'(B_index), 128'd0);
    check("rst_c_index", 128'(C_index), 128'd0);
    check("rst_c_data", C_data_in, 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(4, 4, 4, 1, "identity");
    run(4, 1, 4, 2, "neg128_k1");
    run(4, 2, 4, 2, "neg128_k2");
    run(8, 3, 8, 0, "rand_8x3x8");
    run(5, 2, 6, 0, "padded_5x2x6");
    run(4, 0, 4, 0, "k_zero");
    run(4, 4, 4, 0, "after_k_zero");

    // start pulse while busy must be ignored
    prep(4, 8, 4, 0);
    start_run(4, 8, 4);
    repeat (2) @(negedge clk);
    M = 8'd8; K = 8'd3; N = 8'd8;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(exp_busy(4, 8, 4), "ignored_pulse");

    // reset in the middle of WRITE abandons the run
    prep(4, 4, 4, 0);
    start_run(4, 4, 4);
    guard = 0;
    while (C_wr_en !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      total++;
      bad++;
      $display("FAIL reset_run_timeout got no C write want a C write");
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 128'(busy), 128'd0);
    check("midrun_rst_c_wr_en", 128'(C_wr_en), 128'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(4, 4, 4, 0, "after_reset");

    for (int t = 0; t < 4; t++) begin
      rm = int'($urandom_range(1, 8));
      rk = int'($urandom_range(1, 12));
      rn = int'($urandom_range(1, 8));
      run(rm, rk, rn, 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
